// File: rtl/comparator_pkg.sv
// rtl/comparator_pkg.sv - shared FSM state and result types for the chunked comparator
package comparator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } cmp_state_t;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_result_t;

  localparam cmp_result_t RESULT_NONE = '0;

endpackage

// File: rtl/comparator_chunk.sv
// rtl/comparator_chunk.sv - combinational unsigned compare of one CHUNK-bit slice
module comparator_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  assign eq = (a == b);
  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/comparator_nbit_seq.sv
// rtl/comparator_nbit_seq.sv - multi-cycle MSB-first chunked magnitude comparator with early exit
module comparator_nbit_seq
  import comparator_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            signed_mode,
  input  logic [WIDTH-1:0]                a,
  input  logic [WIDTH-1:0]                b,
  output logic                            busy,
  output logic                            done,
  output logic                            a_equals_b,
  output logic                            a_greater_b,
  output logic                            a_less_b,
  output logic [$clog2(WIDTH/CHUNK):0]    chunks_used
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = $clog2(NCHUNK) + 1;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((WIDTH % CHUNK) != 0 || WIDTH < 2 || WIDTH > 64) begin : g_bad_params
    $error("comparator_nbit_seq: WIDTH must be 2..64 and a multiple of CHUNK");
  end

  cmp_state_t        state;
  cmp_state_t        state_nxt;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [IDX_W-1:0]  idx;
  logic [CHUNK-1:0]  a_slice;
  logic [CHUNK-1:0]  b_slice;
  logic              slice_eq;
  logic              slice_gt;
  logic              slice_lt;
  logic              decide;
  logic [WIDTH-1:0]  msb_mask;
  cmp_result_t       res_q;
  logic [CNT_W-1:0]  chunks_q;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign msb_mask = {signed_mode, {(WIDTH-1){1'b0}}};

  assign a_slice = a_q[idx*CHUNK +: CHUNK];
  assign b_slice = b_q[idx*CHUNK +: CHUNK];

  comparator_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a  (a_slice),
    .b  (b_slice),
    .eq (slice_eq),
    .gt (slice_gt),
    .lt (slice_lt)
  );

  assign decide = (state == ST_COMPARE) && (!slice_eq || (idx == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (start)  state_nxt = ST_COMPARE;
      ST_COMPARE: if (decide) state_nxt = ST_DONE;
      ST_DONE:                state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      ST_COMPARE: busy = 1'b1;
      ST_DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      idx      <= '0;
      res_q    <= RESULT_NONE;
      chunks_q <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        a_q <= a ^ msb_mask;
        b_q <= b ^ msb_mask;
        idx <= IDX_W'(NCHUNK - 1);
      end else if (state == ST_COMPARE) begin
        if (decide) begin
          res_q.eq <= slice_eq;
          res_q.gt <= slice_gt;
          res_q.lt <= slice_lt;
          chunks_q <= CNT_W'(NCHUNK) - CNT_W'(idx);
        end else begin
          idx <= idx - 1'b1;
        end
      end
    end
  end

  assign a_equals_b  = res_q.eq;
  assign a_greater_b = res_q.gt;
  assign a_less_b    = res_q.lt;
  assign chunks_used = chunks_q;

endmodule

// File: tb/tb_comparator_nbit_seq.sv
// tb/tb_comparator_nbit_seq.sv - scoreboard bench for comparator_nbit_seq (WIDTH=16, CHUNK=4)
module tb_comparator_nbit_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy;
  logic        done;
  logic        a_equals_b;
  logic        a_greater_b;
  logic        a_less_b;
  logic [2:0]  chunks_used;

  comparator_nbit_seq #(
    .WIDTH (16),
    .CHUNK (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .a_equals_b  (a_equals_b),
    .a_greater_b (a_greater_b),
    .a_less_b    (a_less_b),
    .chunks_used (chunks_used)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string  name;
    bit     eq;
    bit     gt;
    bit     lt;
    int     chunks;
    longint done_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || done) && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, (n < 30) ? 1 : 0, 1);
  endtask

  // Called at a negedge; leaves the bench at a negedge with the DUT idle.
  task automatic issue(input string name, input bit sm, input logic [15:0] av, input logic [15:0] bv,
                       input bit eq, input bit gt, input bit lt, input int k);
    exp_t e;
    signed_mode = sm;
    a           = av;
    b           = bv;
    start       = 1'b1;
    e.name      = name;
    e.eq        = eq;
    e.gt        = gt;
    e.lt        = lt;
    e.chunks    = k;
    e.done_cyc  = cyc + k + 1;
    sb.push_back(e);
    @(negedge clk);
    start       = 1'b0;
    a           = 16'($urandom);
    b           = 16'($urandom);
    signed_mode = ~sm;
    wait_idle(name);
  endtask

  logic [2:0] last_res = '0;
  bit         seen     = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      seen     = 1'b0;
      last_res = '0;
    end else begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          check({e.name, "_result_eq_gt_lt"}, {a_equals_b, a_greater_b, a_less_b}, {e.eq, e.gt, e.lt});
          check({e.name, "_chunks_used"}, chunks_used, e.chunks);
          check({e.name, "_done_cycle"}, cyc, e.done_cyc);
          check({e.name, "_busy_at_done"}, busy, 0);
        end
        seen     = 1'b1;
        last_res = {a_equals_b, a_greater_b, a_less_b};
      end else begin
        check("result_hold", {a_equals_b, a_greater_b, a_less_b}, last_res);
      end
      if (seen) check("result_onehot", $onehot({a_equals_b, a_greater_b, a_less_b}) ? 1 : 0, 1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of stimulus expected finish before 100000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_results", {a_equals_b, a_greater_b, a_less_b}, 0);
    check("reset_chunks", chunks_used, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    issue("u_eq_1234",        1'b0, 16'h1234, 16'h1234, 1, 0, 0, 4);
    issue("u_gt_8000_7fff",   1'b0, 16'h8000, 16'h7FFF, 0, 1, 0, 1);
    issue("s_lt_8000_7fff",   1'b1, 16'h8000, 16'h7FFF, 0, 0, 1, 1);
    issue("s_lt_ffff_0001",   1'b1, 16'hFFFF, 16'h0001, 0, 0, 1, 1);
    issue("u_gt_00f1_00f0",   1'b0, 16'h00F1, 16'h00F0, 0, 1, 0, 4);
    issue("u_lt_1234_1243",   1'b0, 16'h1234, 16'h1243, 0, 0, 1, 3);
    issue("s_eq_8000",        1'b1, 16'h8000, 16'h8000, 1, 0, 0, 4);
    issue("u_gt_ffff_0000",   1'b0, 16'hFFFF, 16'h0000, 0, 1, 0, 1);
    issue("s_lt_fffe_ffff",   1'b1, 16'hFFFE, 16'hFFFF, 0, 0, 1, 4);
    issue("u_gt_ab00_a000",   1'b0, 16'hAB00, 16'hA000, 0, 1, 0, 2);

    // Second start during COMPARE must not relatch or queue.
    signed_mode = 1'b0;
    a           = 16'h1234;
    b           = 16'h1234;
    start       = 1'b1;
    e.name      = "ignore_restart";
    e.eq        = 1;
    e.gt        = 0;
    e.lt        = 0;
    e.chunks    = 4;
    e.done_cyc  = cyc + 5;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("ignore_busy_in_compare", busy, 1);
    signed_mode = 1'b1;
    a           = 16'h0000;
    b           = 16'hFFFF;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("ignore_restart");
    repeat (4) @(negedge clk);

    // Reset in the second COMPARE cycle aborts without a done pulse.
    signed_mode = 1'b0;
    a           = 16'h1234;
    b           = 16'h1235;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_busy_before_reset", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_results", {a_equals_b, a_greater_b, a_less_b}, 0);
    check("abort_chunks", chunks_used, 0);
    repeat (3) @(negedge clk);
    check("abort_done_held", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", busy, 0);
    issue("after_reset_lt", 1'b0, 16'h0001, 16'h0002, 0, 0, 1, 4);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/comparator_nbit_seq.md
COMPARATOR_NBIT_SEQ -- requirements
Module: comparator_nbit_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits (legal range 2..64).
REQ-002 SHALL have parameter CHUNK, default 4, bits compared per cycle; WIDTH % CHUNK == 0 checked at elaboration; NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request a compare; accepted only in IDLE.
REQ-006 SHALL have port signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
REQ-007 SHALL have port a  input  WIDTH  operand A; sampled with start.
REQ-008 SHALL have port b  input  WIDTH  operand B; sampled with start.
REQ-009 SHALL have port busy  output  1  high while in COMPARE.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a result is valid.
REQ-011 SHALL have port a_equals_b  output  1  registered result A == B.
REQ-012 SHALL have port a_greater_b  output  1  registered result A > B.
REQ-013 SHALL have port a_less_b  output  1  registered result A < B.
REQ-014 SHALL have port chunks_used  output  $clog2(NCHUNK)+1  chunks examined for the last result.

Function
REQ-015 SHALL implement FSM states IDLE, COMPARE, DONE; IDLE->COMPARE on start, COMPARE->DONE on decision, DONE->IDLE unconditionally.
REQ-016 SHALL, on start in IDLE at cycle T, latch a, b, signed_mode, set chunk index to NCHUNK-1, enter COMPARE at T+1.
REQ-017 SHALL, in signed mode, invert the MSB of both latched operands at capture, then compare unsigned (offset-binary equivalence).
REQ-018 SHALL, each COMPARE cycle, compare the indexed CHUNK-bit slices MSB-first; if unequal, decide gt/lt and go to DONE (early exit).
REQ-019 SHALL, if slices are equal and index == 0, decide equal and go to DONE; otherwise decrement index and stay in COMPARE.
REQ-020 SHALL update a_equals_b/a_greater_b/a_less_b and chunks_used on entry to DONE; done=1 for exactly that cycle.
REQ-021 SHALL keep latency from start to done = k+1 cycles, k = chunks examined (1..NCHUNK).
REQ-022 SHALL hold results stable from done until the next done; exactly one of the three result bits high after the first completion.
REQ-023 SHALL ignore start while in COMPARE or DONE (no relatch, no queueing); input changes after capture have no effect.
REQ-024 SHALL keep busy=0 in IDLE and DONE.

Reset
REQ-025 SHALL, on rst_n low, asynchronously force IDLE, busy=0, done=0, all three result bits 0, chunks_used=0, latched operands 0.
REQ-026 SHALL, on reset during COMPARE, abort with no done pulse; first start after rst_n release behaves as from power-up.

Structure
REQ-027 SHALL place the FSM state enum and a result typedef (eq/gt/lt) in package comparator_pkg.
REQ-028 SHALL instantiate one sub-module comparator_chunk: combinational CHUNK-bit compare giving eq/gt/lt.
REQ-029 SHALL contain no latches and no combinational path from inputs to outputs.

Verification (WIDTH=16, CHUNK=4)
REQ-030 SHALL cover: unsigned a=0x1234, b=0x1234 -> a_equals_b=1, chunks_used=4, done 5 cycles after start.
REQ-031 SHALL cover: unsigned a=0x8000, b=0x7FFF -> a_greater_b=1, chunks_used=1, done 2 cycles after start; same with signed_mode=1 -> a_less_b=1.
REQ-032 SHALL cover: signed a=0xFFFF, b=0x0001 -> a_less_b=1; unsigned a=0x00F1, b=0x00F0 -> a_greater_b=1, chunks_used=4.
REQ-033 SHALL cover: start re-asserted with new operands during COMPARE -> ignored, result reflects first operands, single done pulse.
REQ-034 SHALL cover: rst_n low in second COMPARE cycle -> all outputs 0 immediately, no done; next start a=0x0001, b=0x0002 -> a_less_b=1.
